ram_dist_dp: RTL

Parametrised dual-port distributed RAM, the generalised successor of the 64x1 dual-port select-RAM primitive. It has DATA_W-bit words, 2**ADDR_W depth, and an optional registered read stage. It adds a built-in clear engine that sweeps every location to INIT_VAL after reset or on request, with a ready flag. It is used for small register files and lookup tables in Verilator-simulated FPGA designs that need a deterministic memory state without relying on power-up INIT.

---
 rtl/ram_dist_dp.sv | 115 +++++++++++
 1 files changed

// File: rtl/ram_dist_dp.sv
// Dual-port distributed RAM with a built-in sweep that writes INIT_VAL to every word after reset or CLR.
// Latency: reads take 0 cycles (OUT_REG=0) or 1 cycle (OUT_REG=1); a clear takes 2**ADDR_W cycles.
// Backpressure: user writes and CLR are dropped while RDY=0; reads are never stalled.
module ram_dist_dp #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 6,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0,
    parameter bit                 OUT_REG  = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    input  logic              WE,
    input  logic [ADDR_W-1:0] A,
    input  logic [ADDR_W-1:0] DPRA,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] SPO,
    output logic [DATA_W-1:0] DPO,
    output logic              RDY
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEARING = 1'b0,
        ST_RUN      = 1'b1
    } state_t;

    // Power-up values give a deterministic simulation start before the first RST.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};
    state_t            state       = ST_RUN;
    logic              rdy_q       = 1'b1;
    logic [ADDR_W-1:0] ptr         = '0;

    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dat;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        mem_we    = 1'b0;
        mem_addr  = A;
        mem_dat   = D;
        case (state)
            ST_CLEARING: begin
                mem_we   = 1'b1;
                mem_addr = ptr;
                mem_dat  = INIT_VAL;
                ptr_nxt  = ptr + 1'b1;
                if (&ptr) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (CLR) begin
                    state_nxt = ST_CLEARING;
                    ptr_nxt   = '0;
                end else if (WE) begin
                    mem_we = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_CLEARING;
                ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_CLEARING;
            ptr   <= '0;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            rdy_q <= (state_nxt == ST_RUN);
        end
    end

    // Reset blocks the array write so a restarted sweep cannot race a user write.
    always_ff @(posedge CLK) begin
        if (mem_we && !RST) begin
            mem[mem_addr] <= mem_dat;
        end
    end

    assign RDY = rdy_q;

    generate
        if (OUT_REG) begin : g_oreg
            logic [DATA_W-1:0] spo_q = INIT_VAL;
            logic [DATA_W-1:0] dpo_q = INIT_VAL;

            // Nonblocking capture alongside the array write yields read-first behaviour.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    spo_q <= INIT_VAL;
                    dpo_q <= INIT_VAL;
                end else begin
                    spo_q <= mem[A];
                    dpo_q <= mem[DPRA];
                end
            end

            assign SPO = spo_q;
            assign DPO = dpo_q;
        end else begin : g_async
            assign SPO = mem[A];
            assign DPO = mem[DPRA];
        end
    endgenerate
endmodule
